// File: rtl/niossoc_ocimem_pkg.sv
// Shared definitions for the JTAG on-chip-memory controller: jdo field
// positions, CSR bit layout and controller states.
package niossoc_ocimem_pkg;

    localparam int JDO_GO       = 35;
    localparam int JDO_RD       = 34;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_DATA_LSB = 3;

    localparam int CSR_READY = 0;
    localparam int CSR_ERROR = 1;
    localparam int CSR_GO    = 2;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } ocimem_state_e;

    // Pack the monitor flags into the CPU-visible status word.
    function automatic logic [31:0] csr_word(input logic go, input logic err, input logic rdy);
        logic [31:0] w;
        w            = 32'h0000_0000;
        w[CSR_GO]    = go;
        w[CSR_ERROR] = err;
        w[CSR_READY] = rdy;
        return w;
    endfunction

endpackage

// File: rtl/niossoc_jtag_ocimem_ctrl_if.sv
// CPU Avalon-slave bus into the debug-memory controller.
interface niossoc_jtag_ocimem_ctrl_if #(
    parameter int AW = 8
);
    logic [AW:0]   avs_address;
    logic          avs_chipselect;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;

    modport master (
        output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/niossoc_ocimem_ram.sv
// Single-port, byte-enabled debug RAM with a registered read port; written in
// the inference template so it maps onto block RAM. Contents are never reset.
module niossoc_ocimem_ram #(
    parameter int    AW        = 8,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem_r [0:(1<<AW)-1];

    // Byte-lane write and read-first synchronous read.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem_r[addr];
    end
endmodule

// File: rtl/niossoc_jtag_ocimem_ctrl.sv
// Debug-memory controller: executes JTAG address/read/write/go commands on the
// debug RAM, arbitrates them against CPU Avalon accesses, and owns the mailbox.
module niossoc_jtag_ocimem_ctrl
    import niossoc_ocimem_pkg::*;
#(
    parameter int    AW        = 8,
    parameter string INIT_FILE = ""
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [37:0]                        jdo,
    input  logic                               take_action_ocimem_a,
    input  logic                               take_no_action_ocimem_a,
    input  logic                               take_action_ocimem_b,
    niossoc_jtag_ocimem_ctrl_if.slave          avs,
    output logic [31:0]                        MonDReg,
    output logic                               monitor_ready,
    output logic                               monitor_error,
    output logic                               monitor_go
);
    ocimem_state_e state_r, state_next_s;
    logic [AW-1:0] mon_areg_r;
    logic          act_a_s, nact_a_s, act_b_s, jtag_rd_s, any_strobe_s;
    logic          cpu_req_s, wait_s, cpu_ok_s, cpu_csr_s, cpu_rd_s, cpu_wr_s;
    logic [AW-1:0] jdo_addr_s, ram_addr_s;
    logic          ram_we_s;
    logic [3:0]    ram_be_s;
    logic [31:0]   ram_wdata_s, ram_q_s;
    logic          cpu_ram_rd_r;
    logic [31:0]   csr_rdata_r;
    logic          unused_s;

    // Overlapping strobes resolve as action_a > no_action_a > action_b.
    assign act_a_s      = take_action_ocimem_a;
    assign nact_a_s     = take_no_action_ocimem_a & ~take_action_ocimem_a;
    assign act_b_s      = take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
    assign any_strobe_s = act_a_s | nact_a_s | act_b_s;
    assign jtag_rd_s    = nact_a_s | (act_a_s & jdo[JDO_RD]);
    assign jdo_addr_s   = jdo[JDO_ADDR_LSB +: AW];
    assign unused_s     = ^{jdo[37:36], jdo[2:0]};

    assign cpu_req_s = avs.avs_chipselect & (avs.avs_read | avs.avs_write);
    assign wait_s    = cpu_req_s & (any_strobe_s | (state_r == RD_WAIT));
    assign cpu_ok_s  = cpu_req_s & ~wait_s;
    assign cpu_csr_s = avs.avs_address[AW];
    assign cpu_rd_s  = cpu_ok_s & avs.avs_read;
    assign cpu_wr_s  = cpu_ok_s & avs.avs_write & ~avs.avs_read;

    assign avs.avs_waitrequest = wait_s;
    assign avs.avs_readdata    = cpu_ram_rd_r ? ram_q_s : csr_rdata_r;

    // RAM port owner for this cycle: JTAG first, then an accepted CPU access.
    always_comb begin
        ram_addr_s  = mon_areg_r;
        ram_we_s    = 1'b0;
        ram_be_s    = 4'h0;
        ram_wdata_s = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        if (act_a_s) begin
            ram_addr_s = jdo_addr_s;
        end else if (nact_a_s) begin
            ram_addr_s = mon_areg_r;
        end else if (act_b_s) begin
            ram_we_s = 1'b1;
            ram_be_s = 4'hF;
        end else if (cpu_ok_s && !cpu_csr_s) begin
            ram_addr_s  = avs.avs_address[AW-1:0];
            ram_we_s    = cpu_wr_s;
            ram_be_s    = avs.avs_byteenable;
            ram_wdata_s = avs.avs_writedata;
        end else begin
            ram_addr_s = mon_areg_r;
        end
    end

    niossoc_ocimem_ram #(.AW(AW), .INIT_FILE(INIT_FILE)) u_ram (
        .clk   (clk),
        .addr  (ram_addr_s),
        .we    (ram_we_s),
        .be    (ram_be_s),
        .wdata (ram_wdata_s),
        .rdata (ram_q_s)
    );

    // Next-state: a read strobe always (re)arms the capture cycle.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE:    state_next_s = jtag_rd_s ? RD_WAIT : IDLE;
            RD_WAIT: state_next_s = jtag_rd_s ? RD_WAIT : IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register; reset abandons any pending JTAG read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= state_next_s;
    end

    // JTAG address pointer, post-incremented by streaming reads and writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 mon_areg_r <= '0;
        else if (act_a_s)             mon_areg_r <= jdo_addr_s;
        else if (nact_a_s || act_b_s) mon_areg_r <= mon_areg_r + AW'(1);
    end

    // JTAG read data lands one cycle after the RAM read was issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                MonDReg <= 32'h0000_0000;
        else if (state_r == RD_WAIT) MonDReg <= ram_q_s;
    end

    // Mailbox flags: JTAG go restarts the handshake, CPU CSR writes report back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_go    <= 1'b0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else if (act_a_s && jdo[JDO_GO]) begin
            monitor_go    <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else if (cpu_wr_s && cpu_csr_s) begin
            if (avs.avs_writedata[CSR_READY]) begin
                monitor_ready <= 1'b1;
                monitor_go    <= 1'b0;
            end
            if (avs.avs_writedata[CSR_ERROR]) begin
                monitor_error <= 1'b1;
            end
        end
    end

    // CPU read-return select and CSR snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ram_rd_r <= 1'b0;
            csr_rdata_r  <= 32'h0000_0000;
        end else begin
            cpu_ram_rd_r <= cpu_rd_s & ~cpu_csr_s;
            if (cpu_rd_s && cpu_csr_s) begin
                csr_rdata_r <= csr_word(monitor_go, monitor_error, monitor_ready);
            end
        end
    end
endmodule

// File: tb/tb_niossoc_jtag_ocimem_ctrl.sv
// Randomized bench for the debug-memory controller, checked against an
// array-based model of the RAM, address pointer and mailbox flags.
module tb_niossoc_jtag_ocimem_ctrl;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, tn_a = 1'b0, ta_b = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, monitor_go;

    niossoc_jtag_ocimem_ctrl_if #(.AW(AW)) avs_if();

    niossoc_jtag_ocimem_ctrl #(.AW(AW), .INIT_FILE("")) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_no_action_ocimem_a (tn_a),
        .take_action_ocimem_b    (ta_b),
        .avs                     (avs_if),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_m [256];
    logic [7:0]  mona_m;
    logic [31:0] mond_m;
    logic        go_m, err_m, rdy_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic flags_chk(input string tag);
        check(tag, {29'b0, monitor_go, monitor_error, monitor_ready}, {29'b0, go_m, err_m, rdy_m});
    endtask

    task automatic jtag_a(input bit go, input bit rd, input logic [7:0] a);
        @(negedge clk);
        jdo = '0; jdo[35] = go; jdo[34] = rd; jdo[24:17] = a;
        ta_a = 1'b1;
        mona_m = a;
        if (go) begin go_m = 1'b1; rdy_m = 1'b0; err_m = 1'b0; end
        @(negedge clk);
        ta_a = 1'b0;
        if (rd) begin
            check("mond_early", MonDReg, mond_m);
            mond_m = mem_m[a];
            @(negedge clk);
            check("mond_a", MonDReg, mond_m);
        end
        flags_chk("flags_a");
    endtask

    task automatic jtag_n();
        @(negedge clk);
        jdo = {6'($urandom), $urandom};
        tn_a = 1'b1;
        @(negedge clk);
        tn_a = 1'b0;
        check("mond_early", MonDReg, mond_m);
        mond_m = mem_m[mona_m];
        mona_m = mona_m + 8'd1;
        @(negedge clk);
        check("mond_n", MonDReg, mond_m);
    endtask

    task automatic jtag_b(input logic [31:0] d);
        @(negedge clk);
        jdo = '0; jdo[34:3] = d;
        ta_b = 1'b1;
        mem_m[mona_m] = d;
        mona_m = mona_m + 8'd1;
        @(negedge clk);
        ta_b = 1'b0;
    endtask

    task automatic cpu(input bit rd, input bit wr, input logic [8:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, output logic [31:0] rdata);
        int n;
        n = 0;
        @(negedge clk);
        avs_if.avs_chipselect = 1'b1; avs_if.avs_read = rd; avs_if.avs_write = wr;
        avs_if.avs_address = addr; avs_if.avs_writedata = wd; avs_if.avs_byteenable = be;
        #1;
        while (avs_if.avs_waitrequest && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("cpu_accept", {31'b0, avs_if.avs_waitrequest}, 32'd0);
        @(negedge clk);
        rdata = avs_if.avs_readdata;
        avs_if.avs_chipselect = 1'b0; avs_if.avs_read = 1'b0; avs_if.avs_write = 1'b0;
    endtask

    logic [31:0] rd_v, wd_v;
    logic [7:0]  a_v;
    logic [3:0]  be_v;

    initial begin
        avs_if.avs_address = '0; avs_if.avs_chipselect = 1'b0; avs_if.avs_read = 1'b0;
        avs_if.avs_write = 1'b0; avs_if.avs_writedata = '0; avs_if.avs_byteenable = '0;
        mona_m = 8'h00; mond_m = 32'h0; go_m = 1'b0; err_m = 1'b0; rdy_m = 1'b0;
        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mond", MonDReg, 32'h0);
        flags_chk("rst_flags");
        check("rst_rdata", avs_if.avs_readdata, 32'h0);
        check("rst_wait", {31'b0, avs_if.avs_waitrequest}, 32'd0);

        // Pointer writes with post-increment, then readback.
        jtag_a(1'b0, 1'b0, 8'h10);
        jtag_b(32'hDEADBEEF);
        jtag_b(32'h12345678);
        jtag_a(1'b0, 1'b1, 8'h10);
        check("plan_rd_a", MonDReg, 32'hDEADBEEF);
        jtag_n();
        check("plan_rd_n0", MonDReg, 32'hDEADBEEF);
        jtag_n();
        check("plan_rd_n1", MonDReg, 32'h12345678);

        // Pointer wrap from the top word to word zero.
        jtag_a(1'b0, 1'b0, 8'hFF);
        jtag_b(32'hA5A5A5A5);
        jtag_b(32'h5A5A5A5A);
        jtag_a(1'b0, 1'b1, 8'hFF);
        jtag_n();
        jtag_n();
        check("plan_wrap0", MonDReg, 32'h5A5A5A5A);

        // Mailbox handshake.
        jtag_a(1'b1, 1'b0, 8'h20);
        check("plan_go", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h4);
        cpu(1'b0, 1'b1, 9'h100, 32'h3, 4'hF, rd_v);
        rdy_m = 1'b1; err_m = 1'b1; go_m = 1'b0;
        flags_chk("csr_wr_flags");
        cpu(1'b1, 1'b0, 9'h100, 32'h0, 4'hF, rd_v);
        check("plan_csr_rd", rd_v, 32'h3);

        // CPU read colliding with a JTAG read strobe.
        @(negedge clk);
        jdo = '0; jdo[34] = 1'b1; jdo[24:17] = 8'h10; ta_a = 1'b1;
        avs_if.avs_chipselect = 1'b1; avs_if.avs_read = 1'b1; avs_if.avs_address = 9'h011;
        #1 check("coll_wait0", {31'b0, avs_if.avs_waitrequest}, 32'd1);
        @(negedge clk);
        ta_a = 1'b0;
        #1 check("coll_wait1", {31'b0, avs_if.avs_waitrequest}, 32'd1);
        @(negedge clk);
        #1 check("coll_wait2", {31'b0, avs_if.avs_waitrequest}, 32'd0);
        check("coll_mond", MonDReg, 32'hDEADBEEF);
        @(negedge clk);
        check("coll_rdata", avs_if.avs_readdata, 32'h12345678);
        avs_if.avs_chipselect = 1'b0; avs_if.avs_read = 1'b0;
        mona_m = 8'h10; mond_m = 32'hDEADBEEF;

        // Fill the RAM so every later read has a defined expectation.
        jtag_a(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) jtag_b($urandom);

        for (int it = 0; it < 300; it++) begin
            a_v  = 8'($urandom);
            wd_v = $urandom;
            be_v = 4'($urandom);
            case ($urandom_range(0, 6))
                0: jtag_a(($urandom_range(0, 3) == 0), 1'($urandom), a_v);
                1: jtag_n();
                2: jtag_b(wd_v);
                3: begin
                    cpu(1'b0, 1'b1, {1'b0, a_v}, wd_v, be_v, rd_v);
                    for (int b = 0; b < 4; b++)
                        if (be_v[b]) mem_m[a_v][8*b +: 8] = wd_v[8*b +: 8];
                end
                4: begin
                    cpu(1'b1, 1'b0, {1'b0, a_v}, 32'h0, 4'hF, rd_v);
                    check("cpu_ram_rd", rd_v, mem_m[a_v]);
                end
                5: begin
                    cpu(1'b1, 1'b0, {1'b1, a_v}, 32'h0, 4'hF, rd_v);
                    check("cpu_csr_rd", rd_v, {29'b0, go_m, err_m, rdy_m});
                end
                default: begin
                    cpu(1'b0, 1'b1, {1'b1, a_v}, wd_v, be_v, rd_v);
                    if (wd_v[0]) begin rdy_m = 1'b1; go_m = 1'b0; end
                    if (wd_v[1]) err_m = 1'b1;
                end
            endcase
            flags_chk("rand_flags");
        end

        // Reset in the middle of a JTAG read.
        @(negedge clk);
        jdo = '0; jdo[34] = 1'b1; jdo[24:17] = 8'h33; ta_a = 1'b1;
        @(negedge clk);
        ta_a = 1'b0;
        #1 reset_n = 1'b0;
        #1 check("midrst_mond", MonDReg, 32'h0);
        check("midrst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        mona_m = 8'h00; mond_m = 32'h0; go_m = 1'b0; err_m = 1'b0; rdy_m = 1'b0;
        @(negedge clk);
        check("midrst_abort", MonDReg, 32'h0);
        jtag_n();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
